// File: rtl/data_memory_ctrl.sv
// Byte-addressable data memory for the load/store stage.
// Valid/ready request port, one-cycle response pulse, optional wait states.
module data_memory_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DEPTH_WORDS    = 1024,
    parameter int WAIT_STATES    = 0,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [2:0]            req_funct3,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_error,
    output logic                  busy
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    localparam logic [1:0] S_CLEAR = 2'd0;
    localparam logic [1:0] S_IDLE  = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]       state;
    logic [IDX_W-1:0] clr_cnt;
    logic [3:0]       wait_cnt;

    logic             cap_write;
    logic [IDX_W+1:0] cap_addr;
    logic [31:0]      cap_wdata;
    logic [2:0]       cap_funct3;

    logic [31:0] mem [DEPTH_WORDS];

    logic             acc_write;
    logic [IDX_W+1:0] acc_addr;
    logic [31:0]      acc_wdata;
    logic [2:0]       acc_funct3;

    logic             accept;
    logic             commit;
    logic [IDX_W-1:0] idx;
    logic [1:0]       off;
    logic             legal;
    logic             misaligned;
    logic             err;
    logic [3:0]       be;
    logic [31:0]      wsh;
    logic [31:0]      word;
    logic [31:0]      merged;
    logic [31:0]      rsh;
    logic [31:0]      load;

    // Address bits above the array size alias and are deliberately dropped.
    logic unused_addr;
    assign unused_addr = ^req_addr[ADDR_WIDTH-1:IDX_W+2];

    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign rsp_valid = (state == S_RESP);

    assign accept = (state == S_IDLE) && req_valid;
    assign commit = (WAIT_STATES == 0) ? accept
                  : ((state == S_WAIT) && (wait_cnt == 4'd1));

    // With no wait states the access commits on the accept edge itself.
    always_comb begin
        if (state == S_IDLE) begin
            acc_write  = req_write;
            acc_addr   = req_addr[IDX_W+1:0];
            acc_wdata  = req_wdata;
            acc_funct3 = req_funct3;
        end else begin
            acc_write  = cap_write;
            acc_addr   = cap_addr;
            acc_wdata  = cap_wdata;
            acc_funct3 = cap_funct3;
        end
    end

    assign idx = acc_addr[IDX_W+1:2];
    assign off = acc_addr[1:0];

    always_comb begin
        legal      = 1'b0;
        misaligned = 1'b0;
        be         = 4'b0000;
        unique case (acc_funct3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = !acc_write;
            default:                legal = 1'b0;
        endcase
        unique case (acc_funct3[1:0])
            2'b00: be = 4'b0001 << off;
            2'b01: begin
                be         = 4'b0011 << off;
                misaligned = off[0];
            end
            2'b10: begin
                be         = 4'b1111;
                misaligned = (off != 2'b00);
            end
            default: be = 4'b0000;
        endcase
    end

    assign err = !legal || misaligned;
    assign wsh = acc_wdata << {off, 3'b000};
    assign word = mem[idx];
    assign rsh = word >> {off, 3'b000};

    always_comb begin
        merged = word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = wsh[8*i +: 8];
            end
        end
    end

    always_comb begin
        unique case (acc_funct3)
            3'b000:  load = {{24{rsh[7]}}, rsh[7:0]};
            3'b001:  load = {{16{rsh[15]}}, rsh[15:0]};
            3'b100:  load = {24'b0, rsh[7:0]};
            3'b101:  load = {16'b0, rsh[15:0]};
            default: load = word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == S_CLEAR) begin
                mem[clr_cnt] <= '0;
            end else if (commit && acc_write && !err) begin
                mem[idx] <= merged;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
            clr_cnt    <= '0;
            wait_cnt   <= '0;
            cap_write  <= 1'b0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            cap_funct3 <= '0;
            rsp_rdata  <= '0;
            rsp_error  <= 1'b0;
        end else begin
            unique case (state)
                S_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == IDX_W'(DEPTH_WORDS - 1)) begin
                        state <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (req_valid) begin
                        cap_write  <= req_write;
                        cap_addr   <= req_addr[IDX_W+1:0];
                        cap_wdata  <= req_wdata;
                        cap_funct3 <= req_funct3;
                        if (WAIT_STATES == 0) begin
                            state <= S_RESP;
                        end else begin
                            state    <= S_WAIT;
                            wait_cnt <= 4'(WAIT_STATES);
                        end
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state <= S_RESP;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
            if (commit) begin
                rsp_error <= err;
                rsp_rdata <= (err || acc_write) ? 32'h0 : load;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: a byte-array reference model plus literal checks.
// Two instances: default config and a slow, small, no-clear config.
module tb_data_memory_ctrl;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst, rqv, rdy, rqw, rv, re, bsy;
    logic [1:0][31:0] rqa, rqd, rd;
    logic [1:0][2:0]  rqf;

    data_memory_ctrl u_dut0 (
        .clk(clk), .rst(rst[0]),
        .req_valid(rqv[0]), .req_ready(rdy[0]), .req_write(rqw[0]),
        .req_addr(rqa[0]), .req_wdata(rqd[0]), .req_funct3(rqf[0]),
        .rsp_valid(rv[0]), .rsp_rdata(rd[0]), .rsp_error(re[0]),
        .busy(bsy[0])
    );

    data_memory_ctrl #(
        .ADDR_WIDTH(32), .DEPTH_WORDS(16),
        .WAIT_STATES(3), .CLEAR_ON_RESET(1'b0)
    ) u_dut1 (
        .clk(clk), .rst(rst[1]),
        .req_valid(rqv[1]), .req_ready(rdy[1]), .req_write(rqw[1]),
        .req_addr(rqa[1]), .req_wdata(rqd[1]), .req_funct3(rqf[1]),
        .rsp_valid(rv[1]), .rsp_rdata(rd[1]), .rsp_error(re[1]),
        .busy(bsy[1])
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit chk_on = 1'b0;

    logic [7:0]  mb [2][4096];
    bit          pend [2];
    int          due [2];
    logic [31:0] exp_rd [2];
    bit          exp_er [2];
    logic [31:0] hold_rd [2];
    bit          hold_er [2];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int dbytes(int d);
        return (d == 0) ? 4096 : 64;
    endfunction

    function automatic int waits(int d);
        return (d == 0) ? 0 : 3;
    endfunction

    task automatic chk(int d, string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL dut%0d %s: got %08h expected %08h", d, name, act, exp);
        end
    endtask

    // Reference: memory as a flat byte array, addresses wrap at its size.
    function automatic void model(int d, bit wr, logic [31:0] a, logic [31:0] wd,
                                  logic [2:0] f3, output logic [31:0] v, output bit er);
        int sz;
        int ba;
        bit legal;
        ba = int'(a % 32'(dbytes(d)));
        case (f3[1:0])
            2'd0: sz = 1;
            2'd1: sz = 2;
            2'd2: sz = 4;
            default: sz = 0;
        endcase
        legal = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        er = !legal || (sz == 0) || (ba % sz != 0);
        v = 32'h0;
        if (er) return;
        if (wr) begin
            for (int i = 0; i < sz; i++) mb[d][ba+i] = wd[8*i +: 8];
        end else begin
            for (int i = 0; i < sz; i++) v[8*i +: 8] = mb[d][ba+i];
            if (!f3[2] && sz < 4 && v[8*sz-1]) begin
                for (int i = sz; i < 4; i++) v[8*i +: 8] = 8'hFF;
            end
        end
    endfunction

    always @(posedge clk) begin
        #2;
        if (chk_on) begin
            for (int d = 0; d < 2; d++) begin
                if (pend[d] && cyc == due[d]) begin
                    chk(d, "rsp_valid", 32'(rv[d]), 32'd1);
                    chk(d, "rsp_rdata", rd[d], exp_rd[d]);
                    chk(d, "rsp_error", 32'(re[d]), 32'(exp_er[d]));
                    hold_rd[d] = exp_rd[d];
                    hold_er[d] = exp_er[d];
                    pend[d] = 1'b0;
                end else begin
                    chk(d, "rsp_valid idle", 32'(rv[d]), 32'd0);
                    chk(d, "rsp_rdata hold", rd[d], hold_rd[d]);
                    chk(d, "rsp_error hold", 32'(re[d]), 32'(hold_er[d]));
                end
            end
        end
    end

    task automatic req(input int d, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [2:0] f3,
                       input bit abort, output int acc);
        bit r;
        logic [31:0] erd;
        bit eer;
        rqw[d] = wr;
        rqa[d] = a;
        rqd[d] = wd;
        rqf[d] = f3;
        rqv[d] = 1'b1;
        acc = -1;
        for (int k = 0; k < 3000; k++) begin
            r = rdy[d];
            @(posedge clk);
            #1;
            if (r) begin
                acc = cyc;
                break;
            end
        end
        rqv[d] = 1'b0;
        if (acc < 0) begin
            chk(d, "accept timeout", 32'd0, 32'd1);
        end else if (!abort) begin
            model(d, wr, a, wd, f3, erd, eer);
            exp_rd[d] = erd;
            exp_er[d] = eer;
            due[d] = acc + waits(d);
            pend[d] = 1'b1;
        end
    endtask

    task automatic wait_rsp(int d);
        for (int k = 0; k < 40; k++) begin
            if (rv[d]) break;
            @(posedge clk);
            #1;
        end
        chk(d, "rsp timeout", 32'(rv[d]), 32'd1);
    endtask

    task automatic ld(int d, logic [2:0] f3, logic [31:0] a,
                      logic [31:0] lit, bit lit_err, string name);
        int acc;
        req(d, 1'b0, a, 32'h0, f3, 1'b0, acc);
        wait_rsp(d);
        chk(d, name, rd[d], lit);
        chk(d, {name, " err"}, 32'(re[d]), 32'(lit_err));
    endtask

    task automatic st(int d, logic [2:0] f3, logic [31:0] a, logic [31:0] wd,
                      bit lit_err, string name);
        int acc;
        req(d, 1'b1, a, wd, f3, 1'b0, acc);
        wait_rsp(d);
        chk(d, {name, " rdata"}, rd[d], 32'h0);
        chk(d, {name, " err"}, 32'(re[d]), 32'(lit_err));
    endtask

    task automatic pulse_rst(int d);
        rst[d] = 1'b1;
        @(posedge clk);
        #1;
        rst[d] = 1'b0;
        pend[d] = 1'b0;
        hold_rd[d] = 32'h0;
        hold_er[d] = 1'b0;
        if (d == 0) begin
            for (int i = 0; i < 4096; i++) mb[0][i] = 8'h00;
        end
    endtask

    task automatic count_clear();
        int n;
        n = 0;
        while (bsy[0] && n < 3000) begin
            n++;
            @(posedge clk);
            #1;
        end
        chk(0, "clear cycles", 32'(n), 32'd1024);
    endtask

    initial begin
        #2000000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n, n1, n2;
        rst = 2'b11;
        rqv = '0;
        rqw = '0;
        rqa = '0;
        rqd = '0;
        rqf = '0;
        for (int d = 0; d < 2; d++) begin
            pend[d] = 1'b0;
            due[d] = 0;
            exp_rd[d] = 32'h0;
            exp_er[d] = 1'b0;
            hold_rd[d] = 32'h0;
            hold_er[d] = 1'b0;
            for (int i = 0; i < 4096; i++) mb[d][i] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 2'b00;
        chk_on = 1'b1;

        chk(0, "reset ready", 32'(rdy[0]), 32'd0);
        chk(0, "reset busy", 32'(bsy[0]), 32'd1);
        chk(0, "reset rdata", rd[0], 32'h0);
        chk(0, "reset error", 32'(re[0]), 32'd0);
        chk(1, "reset ready", 32'(rdy[1]), 32'd1);
        chk(1, "reset busy", 32'(bsy[1]), 32'd0);
        count_clear();

        st(0, SW, 32'h10, 32'h11223344, 1'b0, "preload");
        ld(0, LW, 32'h10, 32'h11223344, 1'b0, "preload rd");
        pulse_rst(0);
        chk(0, "clear ready", 32'(rdy[0]), 32'd0);
        count_clear();
        ld(0, LW, 32'h10, 32'h0, 1'b0, "cleared w4");

        st(0, SW, 32'h10, 32'hDEADBEEF, 1'b0, "sw");
        ld(0, LB, 32'h13, 32'hFFFFFFDE, 1'b0, "lb 13");
        ld(0, LBU, 32'h11, 32'h000000BE, 1'b0, "lbu 11");
        ld(0, LH, 32'h12, 32'hFFFFDEAD, 1'b0, "lh 12");
        ld(0, LHU, 32'h10, 32'h0000BEEF, 1'b0, "lhu 10");
        st(0, SH, 32'h12, 32'h00001234, 1'b0, "sh");
        st(0, SB, 32'h10, 32'h00000077, 1'b0, "sb");
        ld(0, LW, 32'h10, 32'h1234BE77, 1'b0, "merge");

        st(0, SW, 32'h4, 32'h55667788, 1'b0, "sw w1");
        ld(0, LW, 32'h6, 32'h0, 1'b1, "lw misalign");
        st(0, SH, 32'h11, 32'h0000FFFF, 1'b1, "sh misalign");
        st(0, 3'b011, 32'h4, 32'hFFFFFFFF, 1'b1, "st f3 011");
        ld(0, 3'b011, 32'h4, 32'h0, 1'b1, "ld f3 011");
        ld(0, 3'b110, 32'h4, 32'h0, 1'b1, "ld f3 110");
        st(0, 3'b100, 32'h4, 32'hFFFFFFFF, 1'b1, "st f3 100");
        ld(0, LW, 32'h4, 32'h55667788, 1'b0, "w1 kept");
        ld(0, LW, 32'h10, 32'h1234BE77, 1'b0, "w4 kept");
        ld(0, LH, 32'h6, 32'h00005566, 1'b0, "lh hi half");

        st(0, SW, 32'h1000, 32'hA5A5A5A5, 1'b0, "sw alias");
        ld(0, LW, 32'h0, 32'hA5A5A5A5, 1'b0, "alias lw 0");
        ld(0, LW, 32'hFFFFF000, 32'hA5A5A5A5, 1'b0, "alias hi");
        st(0, SW, 32'hFFC, 32'h0F0F0F0F, 1'b0, "sw last");
        ld(0, LBU, 32'hFFF, 32'h0000000F, 1'b0, "lbu last");

        pulse_rst(0);
        repeat (100) @(posedge clk);
        #1;
        pulse_rst(0);
        count_clear();
        ld(0, LW, 32'h0, 32'h0, 1'b0, "w0 cleared");
        ld(0, LW, 32'hFFC, 32'h0, 1'b0, "last cleared");

        req(1, 1'b1, 32'h8, 32'h0BADF00D, SW, 1'b0, n);
        for (int k = 0; k < 4; k++) begin
            chk(1, "ready low", 32'(rdy[1]), 32'd0);
            chk(1, "valid timing", 32'(rv[1]), (k == 3) ? 32'd1 : 32'd0);
            @(posedge clk);
            #1;
        end
        chk(1, "ready back", 32'(rdy[1]), 32'd1);
        ld(1, LW, 32'h8, 32'h0BADF00D, 1'b0, "slow lw");
        req(1, 1'b0, 32'h8, 32'h0, LW, 1'b0, n1);
        req(1, 1'b0, 32'h8, 32'h0, LB, 1'b0, n2);
        chk(1, "accept gap", 32'(n2 - n1), 32'd5);
        wait_rsp(1);
        chk(1, "lb b2b", rd[1], 32'h0000000D);

        req(1, 1'b1, 32'h8, 32'hCAFEBABE, SW, 1'b1, n);
        pulse_rst(1);
        chk(1, "abort ready", 32'(rdy[1]), 32'd1);
        chk(1, "abort busy", 32'(bsy[1]), 32'd0);
        repeat (8) @(posedge clk);
        #1;
        ld(1, LW, 32'h8, 32'h0BADF00D, 1'b0, "abort kept");
        st(1, SW, 32'h44, 32'h13579BDF, 1'b0, "sw alias1");
        ld(1, LH, 32'h6, 32'h00001357, 1'b0, "alias1 lh");
        ld(1, LHU, 32'h5, 32'h0, 1'b1, "lhu misalign");

        repeat (4) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
